// File: rtl/clk_div_bank.sv
// Multi-channel runtime-programmable clock divider / tick generator with
// shadowed divisors. Optional registered readback port: CLKDIV_READBACK_EN.
module clk_div_bank #(
  parameter int CHANNELS    = 4,
  parameter int WIDTH       = 28,
  parameter int DEFAULT_DIV = 2,
  localparam int ADDR_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  input  logic [CHANNELS-1:0] ch_en,
  output logic [CHANNELS-1:0] div_clk,
  output logic [CHANNELS-1:0] div_tick,
  output logic [CHANNELS-1:0] pend
`ifdef CLKDIV_READBACK_EN
  ,
  input  logic [ADDR_W-1:0]   rd_addr,
  input  logic                rd_sel,
  output logic [WIDTH-1:0]    rd_data
`endif
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO = WIDTH'(2);
  localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0]    div_q [CHANNELS];
  logic [WIDTH-1:0]    shd_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    div_n [CHANNELS];
  logic [WIDTH-1:0]    shd_n [CHANNELS];
  logic [WIDTH-1:0]    cnt_n [CHANNELS];
  logic [CHANNELS-1:0] clk_n, tick_n, pend_n;
  logic [CHANNELS-1:0] wr_hit, last, bnd, apply;
  logic [31:0]         wa;

  assign wa = 32'(wr_addr);

  // Outputs are registered from the next-state values so that they line up
  // with the counter value held during the same cycle.
  always_comb begin
    div_n  = div_q;
    shd_n  = shd_q;
    cnt_n  = cnt_q;
    pend_n = pend;
    clk_n  = '0;
    tick_n = '0;
    wr_hit = '0;
    last   = '0;
    bnd    = '0;
    apply  = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      wr_hit[i] = wr_en && (wa == i);
      last[i]   = (div_q[i] >= TWO) && (cnt_q[i] == div_q[i] - ONE);
      bnd[i]    = !ch_en[i] || (div_q[i] <= ONE) || last[i];
      apply[i]  = bnd[i] && pend[i];

      shd_n[i]  = wr_hit[i] ? wr_data : shd_q[i];
      pend_n[i] = wr_hit[i] || (pend[i] && !apply[i]);
      div_n[i]  = apply[i] ? shd_q[i] : div_q[i];
      cnt_n[i]  = bnd[i] ? '0 : cnt_q[i] + ONE;

      clk_n[i]  = ch_en[i] && (div_n[i] >= TWO) && (cnt_n[i] >= (div_n[i] >> 1));
      tick_n[i] = ch_en[i] && ((div_n[i] == ONE) ||
                  ((div_n[i] >= TWO) && (cnt_n[i] == div_n[i] - ONE)));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        div_q[i] <= DEF;
        shd_q[i] <= DEF;
        cnt_q[i] <= '0;
      end
      div_clk  <= '0;
      div_tick <= '0;
      pend     <= '0;
    end else begin
      div_q    <= div_n;
      shd_q    <= shd_n;
      cnt_q    <= cnt_n;
      div_clk  <= clk_n;
      div_tick <= tick_n;
      pend     <= pend_n;
    end
  end

`ifdef CLKDIV_READBACK_EN
  logic [31:0]      ra;
  logic [WIDTH-1:0] rd_n;

  assign ra = 32'(rd_addr);

  always_comb begin
    rd_n = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (ra == i) rd_n = rd_sel ? cnt_q[i] : div_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_data <= '0;
    else        rd_data <= rd_n;
  end
`endif

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: directed table, corner sequences and
// randomized traffic against a period/phase reference model.
module tb_clk_div_bank;
  localparam int CH = 5;
  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [CH-1:0] ch_en;
  logic [CH-1:0] div_clk, div_tick, pend;
`ifdef CLKDIV_READBACK_EN
  logic [AW-1:0] rd_addr;
  logic          rd_sel;
  logic [W-1:0]  rd_data;
`endif

  always #5 clk = ~clk;

  clk_div_bank #(.CHANNELS(CH), .WIDTH(W), .DEFAULT_DIV(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .ch_en(ch_en), .div_clk(div_clk),
    .div_tick(div_tick), .pend(pend)
`ifdef CLKDIV_READBACK_EN
    , .rd_addr(rd_addr), .rd_sel(rd_sel), .rd_data(rd_data)
`endif
  );

  int errors = 0;
  int checks = 0;

  // Reference: each channel is a position p inside a period of length div.
  int            m_div [CH];
  int            m_shd [CH];
  int            m_p   [CH];
  bit            m_pend[CH];
  logic [CH-1:0] e_clk, e_tick, e_pend;
  int            e_rd;

  typedef struct {
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [CH-1:0] en;
    logic [CH-1:0] x_clk, x_tick, x_pend;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_div[c] = 2; m_shd[c] = 2; m_p[c] = 0; m_pend[c] = 0;
    end
    e_clk = '0; e_tick = '0; e_pend = '0; e_rd = 0;
  endtask

  task automatic model_edge();
    bit en, bnd, apply;
`ifdef CLKDIV_READBACK_EN
    e_rd = (int'(rd_addr) < CH) ? (rd_sel ? m_p[rd_addr] : m_div[rd_addr]) : 0;
`endif
    for (int c = 0; c < CH; c++) begin
      en    = ch_en[c];
      bnd   = !en || m_div[c] <= 1 || m_p[c] == m_div[c] - 1;
      apply = bnd && m_pend[c];
      if (!en || m_div[c] <= 1) m_p[c] = 0;
      else                      m_p[c] = (m_p[c] + 1) % m_div[c];
      if (apply) begin
        m_div[c] = m_shd[c];
        m_p[c]   = 0;
      end
      if (wr_en && int'(wr_addr) == c) begin
        m_shd[c]  = int'(wr_data);
        m_pend[c] = 1;
      end else if (apply) begin
        m_pend[c] = 0;
      end
      e_clk[c]  = en && m_div[c] >= 2 && m_p[c] >= m_div[c] / 2;
      e_tick[c] = en && (m_div[c] == 1 || (m_div[c] >= 2 && m_p[c] == m_div[c] - 1));
      e_pend[c] = m_pend[c];
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    chk("div_clk", 32'(div_clk), 32'(e_clk));
    chk("div_tick", 32'(div_tick), 32'(e_tick));
    chk("pend", 32'(pend), 32'(e_pend));
`ifdef CLKDIV_READBACK_EN
    chk("rd_data", 32'(rd_data), 32'(e_rd));
`endif
  endtask

  task automatic wait_phase(input int c, input int d, input int p, input string name);
    int n = 0;
    while (!(m_div[c] == d && m_p[c] == p && ch_en[c]) && n < 60) begin
      step();
      n++;
    end
    chk(name, 32'(n < 60), 32'd1);
  endtask

  task automatic chk_reset_outputs(input string name);
    chk(name, 32'({div_clk, div_tick, pend}), 32'd0);
`ifdef CLKDIV_READBACK_EN
    chk({name, "_rd"}, 32'(rd_data), 32'd0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    tbl[0] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
    tbl[1] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tbl[2] = '{1'b1, 3'd0, 8'd5, 5'b00001, 5'b00001, 5'b00001, 5'b00001};
    tbl[3] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tbl[4] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tbl[5] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    tbl[6] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00001, 5'b00000, 5'b00000};
    tbl[7] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00001, 5'b00001, 5'b00000};
    tbl[8] = '{1'b0, 3'd0, 8'd0, 5'b00001, 5'b00000, 5'b00000, 5'b00000};

    rst_n = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; ch_en = '0;
`ifdef CLKDIV_READBACK_EN
    rd_addr = '0; rd_sel = 1'b0;
`endif
    model_reset();
    #12;
    chk_reset_outputs("reset_state");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd; ch_en = tbl[i].en;
      step();
      chk($sformatf("tbl%0d_clk", i), 32'(div_clk), 32'(tbl[i].x_clk));
      chk($sformatf("tbl%0d_tick", i), 32'(div_tick), 32'(tbl[i].x_tick));
      chk($sformatf("tbl%0d_pend", i), 32'(pend), 32'(tbl[i].x_pend));
    end
    wr_en = 1'b0;

    // ch1: write 7 in its boundary cycle, overwrite with 3 before the next one
    ch_en = 5'b00011;
    wait_phase(1, 2, 1, "seqA_sync");
    wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'd7;
    step();
    chk("seqA_pend_kept", 32'(pend[1]), 32'd1);
    wr_data = 8'd3;
    step();
    wr_en = 1'b0;
    repeat (10) step();

    // ch2: divisor 0 stops it, divisor 1 makes a constant tick
    ch_en = 5'b00111;
    wr_en = 1'b1; wr_addr = 3'd2; wr_data = 8'd0;
    step();
    wr_en = 1'b0;
    repeat (6) step();
    chk("seqB_d0_out", 32'({div_clk[2], div_tick[2]}), 32'd0);
    wr_en = 1'b1; wr_data = 8'd1;
    step();
    wr_en = 1'b0;
    repeat (6) step();
    chk("seqB_d1_tick", 32'(div_tick[2]), 32'd1);
    chk("seqB_d1_clk", 32'(div_clk[2]), 32'd0);

    // ch0: D=6, disable in the high phase, invalid writes, re-enable
    wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'd6;
    step();
    wr_en = 1'b0;
    wait_phase(0, 6, 4, "seqC_sync");
    ch_en[0] = 1'b0;
    step();
    chk("seqC_dis_out", 32'({div_clk[0], div_tick[0]}), 32'd0);
    for (int k = 0; k < 10; k++) begin
      wr_en   = (k == 2 || k == 5);
      wr_addr = (k == 2) ? 3'd5 : 3'd7;
      wr_data = 8'd1;
      step();
    end
    wr_en = 1'b0;
    chk("seqC_bad_addr_pend", 32'(pend), 32'd0);
    ch_en[0] = 1'b1;
    n = 0;
    do begin
      step();
      n++;
    end while (!div_tick[0] && n < 20);
    chk("seqC_reen_latency", 32'(n), 32'd5);

    // randomized traffic with an asynchronous reset in the middle
    for (int cyc = 0; cyc < 3000; cyc++) begin
      wr_en   = ($urandom % 6) == 0;
      wr_addr = AW'($urandom % 8);
      wr_data = (($urandom % 5) == 0) ? W'($urandom % 3) : W'($urandom_range(2, 12));
      if (($urandom % 10) == 0) ch_en[$urandom % CH] = ~ch_en[$urandom % CH];
`ifdef CLKDIV_READBACK_EN
      rd_addr = AW'($urandom % 8);
      rd_sel  = 1'($urandom % 2);
`endif
      step();
      if (cyc == 1500) begin
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrun_reset");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/clk_div_bank.md
Name: clk_div_bank

Overview:
Parametrised, runtime-programmable multi-channel clock divider and tick generator. It is the successor to the fixed single-divisor divider in the top level. It runs from the master CPU clock and gives each channel its own divided clock (glitch-free, registered) and a one-cycle tick enable for timers, UART baud and LED blink logic. Divisors are written over a simple register port, typically from com_block. New divisors apply only at period boundaries.

Parameters:
CHANNELS, 4, number of independent divider channels (1..16)
WIDTH, 28, divisor/counter width in bits
DEFAULT_DIV, 2, divisor loaded into every channel at reset (must be < 2^WIDTH)
ADDR_W, $clog2(CHANNELS) (min 1), channel select width; derived, not overridden

Ports:
clk  in  1  master clock; all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  divisor write strobe, one cycle
wr_addr  in  ADDR_W  target channel for write
wr_data  in  WIDTH  new divisor D
ch_en  in  CHANNELS  per-channel run enable
div_clk  out  CHANNELS  divided clock per channel, registered
div_tick  out  CHANNELS  one-cycle pulse per period, registered
pend  out  CHANNELS  shadow divisor written but not yet applied

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst_n.
- Per channel state:
  - active divisor div (WIDTH)
  - shadow divisor shd (WIDTH)
  - counter cnt (WIDTH)
- Reset (rst_n=0, immediate):
  - div=shd=DEFAULT_DIV, cnt=0
  - div_clk=0, div_tick=0, pend=0
- Running (ch_en[i]=1, div>=2):
  - cnt counts 0..div-1, then wraps to 0.
  - div_clk == (cnt >= div>>1); low floor(div/2) cycles, high ceil(div/2) cycles.
  - div_tick high exactly in the cycle where cnt == div-1; period = div cycles.
  - Both outputs are flops, never combinational decode.
- div==1: div_tick high every enabled cycle; div_clk held 0; cnt stays 0.
- div==0: channel stopped; cnt=0, div_clk=0, div_tick=0.
- ch_en[i] deasserted: next edge forces cnt=0, div_clk=0, div_tick=0.
- ch_en[i] reasserted: counting restarts from cnt=0; first tick after div cycles.
- Write (wr_en=1, wr_addr<CHANNELS):
  - shd[wr_addr] <= wr_data; pend[wr_addr] <= 1 on next edge.
  - wr_addr >= CHANNELS: write ignored, no state change.
- Application of shadow:
  - Boundary = cycle with cnt==div-1 (or any cycle if channel disabled or div<=1).
  - At a boundary with pend=1: div <= shd, cnt <= 0, pend <= 0.
  - The divisor/counter update uses shd and pend as registered before the edge; a write in the boundary cycle applies at the next boundary.
  - Writes in the boundary cycle must not clear pend; it stays 1.
  - A second write before application overwrites shd; only the last value applies.
- No runt pulses: the div_clk high phase is never shortened by a divisor change.
- rst_n asserted mid-period: all channels return to reset state asynchronously; pending writes are lost.
- Channels are fully independent; simultaneous boundaries on several channels are legal.

Optional Feature:
Macro CLKDIV_READBACK_EN.
- Defined: adds ports rd_addr (in, ADDR_W) and rd_sel (in, 1) plus rd_data (out, WIDTH).
  - rd_sel=0 returns div[rd_addr]; rd_sel=1 returns cnt[rd_addr].
  - rd_data is registered; 1-cycle latency; reset value 0.
  - rd_addr >= CHANNELS returns 0.
- Undefined: ports absent, no read mux logic; all other behaviour identical.

Test Plan:
- Reset release, ch_en=4'b0001, default D=2 -> div_clk[0] toggles every cycle; div_tick[0] every 2nd cycle; ch1-3 outputs stay 0.
- Write ch0 D=5 while running -> pend[0]=1 until the current period ends; then div_clk[0] low 2/high 3, tick period 5, pend[0]=0.
- Write ch1 D=7 then D=3 before the boundary -> only D=3 applied (low 1/high 2); D=7 never observed.
- Write ch2 D=0, then D=1 -> outputs held 0; then div_tick[2] constant high, div_clk[2]=0.
- Deassert ch_en[0] mid-high-phase with D=6, reassert 10 cycles later -> outputs 0 next edge; first tick 6 cycles after re-enable; wr_addr=CHANNELS ignored.
- CLKDIV_READBACK_EN: ch3 D=9, rd_sel=0 -> rd_data=9 one cycle later; rd_sel=1 tracks cnt 0..8; rst_n low mid-run -> rd_data=0 immediately.
